mult16s_rr_scheduler: RTL

- Shares one signed 16x16 Kogge-Stone multiplier core (mult16s_normal_koggestone, combinational) between NUM_REQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port.
- Results come out on one shared tagged response bus with backpressure, buffered in an internal result FIFO.
- Sits between compute clients and the multiplier; replaces per-client multipliers in area-constrained builds.

---
 rtl/mult16s_rr_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult16s_rr_scheduler.sv
// Round-robin front end sharing one signed 16x16 Kogge-Stone multiplier among NUM_REQ clients,
// with a credit-protected result FIFO feeding one tagged response bus.

module mult16s_normal_koggestone (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);
   logic [31:0]       a_ext;
   logic [14:0][31:0] pp;
   logic [31:0]       row_sign;
   logic [31:0]       acc;
   logic [31:0]       x;
   logic [31:0]       y;
   logic [5:0][31:0]  g_lvl;
   logic [4:0][31:0]  p_lvl;
   logic              unused_cout;
   localparam logic   CIN = 1'b1;

   assign a_ext = {{16{a[15]}}, a};

   for (genvar gi = 0; gi < 15; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? (a_ext << gi) : '0;
   end

   // The multiplier's sign bit weighs -2^15, so its row is subtracted rather than added.
   assign row_sign = b[15] ? (a_ext << 15) : '0;

   always_comb begin
      acc = '0;
      for (int i = 0; i < 15; i++) begin
         acc = acc + pp[i];
      end
   end

   assign x = acc;
   assign y = ~row_sign;

   assign g_lvl[0] = (x & y) | {31'b0, (x[0] ^ y[0]) & CIN};
   assign p_lvl[0] = x ^ y;

   for (genvar gk = 0; gk < 5; gk++) begin : g_lvl_stage
      for (genvar gi = 0; gi < 32; gi++) begin : g_bit
         if (gi >= (1 << gk)) begin : g_merge
            assign g_lvl[gk+1][gi] = g_lvl[gk][gi] | (p_lvl[gk][gi] & g_lvl[gk][gi-(1<<gk)]);
            if (gk < 4) begin : g_pmerge
               assign p_lvl[gk+1][gi] = p_lvl[gk][gi] & p_lvl[gk][gi-(1<<gk)];
            end
         end else begin : g_pass
            assign g_lvl[gk+1][gi] = g_lvl[gk][gi];
            if (gk < 4) begin : g_ppass
               assign p_lvl[gk+1][gi] = p_lvl[gk][gi];
            end
         end
      end
   end

   assign p           = p_lvl[0] ^ {g_lvl[5][30:0], CIN};
   assign unused_cout = g_lvl[5][31];
endmodule

module mult16s_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [16*NUM_REQ-1:0] req_a,
   input  logic [16*NUM_REQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_product,
   output logic                  busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic             s1_valid_q, s1_valid_d;
   logic [15:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [ID_W-1:0]  s1_id_q, s1_id_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ID_W+31:0] fifo_mem [FIFO_DEPTH];
   logic [ID_W+31:0] head;
   logic [CNT_W:0]   credit_use;
   logic             can_issue;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic [31:0]      product;
   logic             push, pop;
   int               idx;

   mult16s_normal_koggestone u_core (.a(s1_a_q), .b(s1_b_q), .p(product));

   // A pop in the same cycle is deliberately not counted as credit, keeping the check off rsp_ready.
   assign credit_use = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
   assign can_issue  = credit_use < (CNT_W+1)'(FIFO_DEPTH);

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = ptr_q;
      idx         = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(ptr_q) + off) % NUM_REQ;
         if (!grant_valid && can_issue && req_valid[idx]) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;
   assign push      = s1_valid_q;
   assign pop       = (count_q != '0) && rsp_ready;

   always_comb begin
      ptr_d      = grant_valid ? grant_id : ptr_q;
      s1_valid_d = grant_valid;
      s1_a_d     = grant_valid ? req_a[16*grant_id +: 16] : s1_a_q;
      s1_b_d     = grant_valid ? req_b[16*grant_id +: 16] : s1_b_q;
      s1_id_d    = grant_valid ? grant_id : s1_id_q;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= ID_W'(NUM_REQ - 1);
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_id_q    <= s1_id_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage is not reset; the outputs are masked while the FIFO is empty instead.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {s1_id_q, product};
      end
   end

   assign head        = fifo_mem[rd_ptr_q];
   assign rsp_valid   = (count_q != '0);
   assign rsp_id      = rsp_valid ? head[ID_W+31:32] : '0;
   assign rsp_product = rsp_valid ? head[31:0] : '0;
   assign busy        = s1_valid_q | rsp_valid;
endmodule
